regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer in front of `register_file`. It shares the register file's write ports between the CPU pipeline (two scalar write ports) and the VPU (the parallel vertex-block write V0–V7 plus the return object, gated by `we_VPU`). It holds one VPU result in a skid buffer and delays it while the CPU writes any address the VPU write would also update. A bounded starvation counter forces the VPU write through. It also flags CPU read hazards on vertex and return-object registers while a VPU job is outstanding.

---
 rtl/cpu_regs_pkg.sv | 21 ++
 rtl/vpu_skid_buf.sv | 23 ++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared register-file constants for the write-back path: the VPU destination set
// (V0..V7 at R8..R15, return object at R23) and the write-back arbiter state type.
package cpu_regs_pkg;

   localparam logic [4:0]  VREG_BASE = 5'd8;
   localparam int unsigned VREG_CNT  = 8;
   localparam logic [4:0]  RO_ADDR   = 5'd23;

   typedef enum logic [1:0] {IDLE, PEND, FORCE} wb_state_t;

   // One complete VPU result: 8 vertex words plus the return object (144 bits)
   typedef struct packed {
      logic [15:0]                ro;
      logic [VREG_CNT-1:0][15:0]  v;
   } vpu_result_t;

   function automatic logic in_vset(input logic [4:0] addr);
      return ((addr >= VREG_BASE) && (addr < VREG_BASE + 5'(VREG_CNT))) || (addr == RO_ADDR);
   endfunction

endpackage

// File: rtl/vpu_skid_buf.sv
// One-entry holding register for a VPU result, with load and clear.
module vpu_skid_buf
   import cpu_regs_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  vpu_result_t d,
   output vpu_result_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write ports between the CPU pipeline and one buffered VPU
// result, deferring the VPU write on address overlap up to a bounded starvation limit.
module regfile_wb_arbiter
   import cpu_regs_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_we_0,
   input  logic             cpu_we_1,
   input  logic [4:0]       cpu_waddr_0,
   input  logic [4:0]       cpu_waddr_1,
   input  logic [15:0]      cpu_wdata_0,
   input  logic [15:0]      cpu_wdata_1,
   input  logic             cpu_re_0,
   input  logic             cpu_re_1,
   input  logic [4:0]       cpu_raddr_0,
   input  logic [4:0]       cpu_raddr_1,
   input  logic             vpu_start,
   input  logic             vpu_valid,
   output logic             vpu_ready,
   input  logic [7:0][15:0] vpu_vdata,
   input  logic [15:0]      vpu_ro,
   output logic             we_CPU_0,
   output logic             we_CPU_1,
   output logic [4:0]       wrt_addr_0,
   output logic [4:0]       wrt_addr_1,
   output logic [15:0]      wrt_data_0,
   output logic [15:0]      wrt_data_1,
   output logic             we_VPU,
   output logic [7:0][15:0] wrt_V,
   output logic [15:0]      return_obj,
   output logic             cpu_stall,
   output logic             cpu_hazard
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   wb_state_t   state_q;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic        conflict;
   logic        load;
   vpu_result_t buf_d;
   vpu_result_t buf_q;

   assign conflict = (cpu_we_0 && in_vset(cpu_waddr_0)) || (cpu_we_1 && in_vset(cpu_waddr_1));

   assign vpu_ready = (state_q == IDLE) && rst_n;
   assign load      = vpu_valid && vpu_ready;
   assign we_VPU    = ((state_q == PEND) && !conflict) || (state_q == FORCE);
   assign cpu_stall = (state_q == FORCE);

   // CPU writes pass straight through except during the one-cycle forced VPU write
   assign we_CPU_0   = cpu_we_0 && (state_q != FORCE);
   assign we_CPU_1   = cpu_we_1 && (state_q != FORCE);
   assign wrt_addr_0 = cpu_waddr_0;
   assign wrt_addr_1 = cpu_waddr_1;
   assign wrt_data_0 = cpu_wdata_0;
   assign wrt_data_1 = cpu_wdata_1;

   assign cpu_hazard = busy_q && ((cpu_re_0 && in_vset(cpu_raddr_0)) ||
                                  (cpu_re_1 && in_vset(cpu_raddr_1)));

   assign buf_d.v    = vpu_vdata;
   assign buf_d.ro   = vpu_ro;
   assign wrt_V      = buf_q.v;
   assign return_obj = buf_q.ro;

   vpu_skid_buf u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .clear (we_VPU),
      .d     (buf_d),
      .q     (buf_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         // A new job issued in the same cycle as a write-back keeps the flag set
         if (vpu_start) begin
            busy_q <= 1'b1;
         end else if (we_VPU) begin
            busy_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (vpu_valid) state_q <= PEND;
            end
            PEND: begin
               if (conflict) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q + 4'd1 == LIMIT) state_q <= FORCE;
               end else begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end
            end
            FORCE: begin
               state_q <= IDLE;
               cnt_q   <= 4'd0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one task per scenario, inline comparisons.
module tb_regfile_wb_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cpu_we_0, cpu_we_1;
   logic [4:0]       cpu_waddr_0, cpu_waddr_1;
   logic [15:0]      cpu_wdata_0, cpu_wdata_1;
   logic             cpu_re_0, cpu_re_1;
   logic [4:0]       cpu_raddr_0, cpu_raddr_1;
   logic             vpu_start, vpu_valid, vpu_ready;
   logic [7:0][15:0] vpu_vdata;
   logic [15:0]      vpu_ro;
   logic             we_CPU_0, we_CPU_1;
   logic [4:0]       wrt_addr_0, wrt_addr_1;
   logic [15:0]      wrt_data_0, wrt_data_1;
   logic             we_VPU;
   logic [7:0][15:0] wrt_V;
   logic [15:0]      return_obj;
   logic             cpu_stall, cpu_hazard;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_we_0    (cpu_we_0),
      .cpu_we_1    (cpu_we_1),
      .cpu_waddr_0 (cpu_waddr_0),
      .cpu_waddr_1 (cpu_waddr_1),
      .cpu_wdata_0 (cpu_wdata_0),
      .cpu_wdata_1 (cpu_wdata_1),
      .cpu_re_0    (cpu_re_0),
      .cpu_re_1    (cpu_re_1),
      .cpu_raddr_0 (cpu_raddr_0),
      .cpu_raddr_1 (cpu_raddr_1),
      .vpu_start   (vpu_start),
      .vpu_valid   (vpu_valid),
      .vpu_ready   (vpu_ready),
      .vpu_vdata   (vpu_vdata),
      .vpu_ro      (vpu_ro),
      .we_CPU_0    (we_CPU_0),
      .we_CPU_1    (we_CPU_1),
      .wrt_addr_0  (wrt_addr_0),
      .wrt_addr_1  (wrt_addr_1),
      .wrt_data_0  (wrt_data_0),
      .wrt_data_1  (wrt_data_1),
      .we_VPU      (we_VPU),
      .wrt_V       (wrt_V),
      .return_obj  (return_obj),
      .cpu_stall   (cpu_stall),
      .cpu_hazard  (cpu_hazard)
   );

   // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cpu_we_0 = 0; cpu_we_1 = 0; cpu_waddr_0 = 0; cpu_waddr_1 = 0;
      cpu_wdata_0 = 0; cpu_wdata_1 = 0; cpu_re_0 = 0; cpu_re_1 = 0;
      cpu_raddr_0 = 0; cpu_raddr_1 = 0; vpu_start = 0; vpu_valid = 0;
      vpu_vdata = '0; vpu_ro = 0;
   endtask

   // Presents one result for one cycle; returns 1 unit after the accepting edge (PEND).
   task automatic accept(input logic [7:0][15:0] v, input logic [15:0] ro);
      vpu_valid = 1; vpu_vdata = v; vpu_ro = ro;
      next_cycle();
      vpu_valid = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #12;
      n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL rst_we_vpu: got %b want 0", we_VPU); end
      n_cmp++; if (we_CPU_0 !== 1'b0) begin n_err++; $display("FAIL rst_we_cpu0: got %b want 0", we_CPU_0); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
      n_cmp++; if (vpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", vpu_ready); end
      n_cmp++; if (wrt_V !== '0) begin n_err++; $display("FAIL rst_wrt_v: got %h want 0", wrt_V); end
      n_cmp++; if (return_obj !== 16'h0) begin n_err++; $display("FAIL rst_ro: got %h want 0", return_obj); end
      n_cmp++; if (cpu_hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %b want 0", cpu_hazard); end
      @(negedge clk);
      rst_n = 1;
      next_cycle();
      n_cmp++; if (vpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", vpu_ready); end
   endtask

   task automatic test_no_conflict();
      logic [7:0][15:0] v;
      v = {16'hCCEE, 16'hCBED, 16'hCAEC, 16'hC9EB, 16'hC8EA, 16'hC7E9, 16'hC6E8, 16'hABCD};
      #1;
      n_cmp++; if (vpu_ready !== 1'b1) begin n_err++; $display("FAIL nc_ready: got %b want 1", vpu_ready); end
      accept(v, 16'h0017);
      #1;
      n_cmp++; if (we_VPU !== 1'b1) begin n_err++; $display("FAIL nc_we_vpu: got %b want 1", we_VPU); end
      n_cmp++; if (wrt_V !== v) begin n_err++; $display("FAIL nc_wrt_v: got %h want %h", wrt_V, v); end
      n_cmp++; if (return_obj !== 16'h0017) begin n_err++; $display("FAIL nc_ro: got %h want 0017", return_obj); end
      n_cmp++; if (vpu_ready !== 1'b0) begin n_err++; $display("FAIL nc_ready_pend: got %b want 0", vpu_ready); end
      next_cycle();
      n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL nc_we_vpu_once: got %b want 0", we_VPU); end
      n_cmp++; if (vpu_ready !== 1'b1) begin n_err++; $display("FAIL nc_ready_back: got %b want 1", vpu_ready); end
   endtask

   task automatic test_conflict_release();
      logic [7:0][15:0] v;
      v = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
      accept(v, 16'h1234);
      cpu_we_0 = 1; cpu_waddr_0 = 5'd9; cpu_wdata_0 = 16'hBEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL cr_defer%0d: got %b want 0", i, we_VPU); end
         n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cr_stall%0d: got %b want 0", i, cpu_stall); end
         n_cmp++; if (we_CPU_0 !== 1'b1) begin n_err++; $display("FAIL cr_cpu%0d: got %b want 1", i, we_CPU_0); end
         next_cycle();
      end
      cpu_we_0 = 0;
      #1;
      n_cmp++; if (we_VPU !== 1'b1) begin n_err++; $display("FAIL cr_release: got %b want 1", we_VPU); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cr_stall_rel: got %b want 0", cpu_stall); end
      n_cmp++; if (return_obj !== 16'h1234) begin n_err++; $display("FAIL cr_ro: got %h want 1234", return_obj); end
      next_cycle();
   endtask

   task automatic test_starvation();
      logic [7:0][15:0] v;
      v = {8{16'h5A5A}};
      accept(v, 16'h00FF);
      cpu_we_1 = 1; cpu_waddr_1 = 5'd23; cpu_wdata_1 = 16'hF00D;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL sv_defer%0d: got %b want 0", i, we_VPU); end
         n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL sv_stall%0d: got %b want 0", i, cpu_stall); end
         n_cmp++; if (we_CPU_1 !== 1'b1) begin n_err++; $display("FAIL sv_cpu%0d: got %b want 1", i, we_CPU_1); end
         next_cycle();
      end
      #1;
      n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL sv_force_stall: got %b want 1", cpu_stall); end
      n_cmp++; if (we_CPU_1 !== 1'b0) begin n_err++; $display("FAIL sv_force_mask: got %b want 0", we_CPU_1); end
      n_cmp++; if (we_VPU !== 1'b1) begin n_err++; $display("FAIL sv_force_we: got %b want 1", we_VPU); end
      n_cmp++; if (wrt_V !== v) begin n_err++; $display("FAIL sv_force_v: got %h want %h", wrt_V, v); end
      next_cycle();
      #1;
      n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL sv_after_stall: got %b want 0", cpu_stall); end
      n_cmp++; if (we_CPU_1 !== 1'b1) begin n_err++; $display("FAIL sv_after_cpu: got %b want 1", we_CPU_1); end
      n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL sv_after_we: got %b want 0", we_VPU); end
      n_cmp++; if (vpu_ready !== 1'b1) begin n_err++; $display("FAIL sv_after_ready: got %b want 1", vpu_ready); end
      cpu_we_1 = 0;
      next_cycle();
   endtask

   task automatic test_disjoint();
      logic [7:0][15:0] v;
      v = {8{16'h0F0F}};
      accept(v, 16'h0042);
      cpu_we_0 = 1; cpu_waddr_0 = 5'd3; cpu_wdata_0 = 16'h0003;
      #1;
      n_cmp++; if (we_VPU !== 1'b1) begin n_err++; $display("FAIL dj_we_vpu: got %b want 1", we_VPU); end
      n_cmp++; if (we_CPU_0 !== 1'b1) begin n_err++; $display("FAIL dj_we_cpu: got %b want 1", we_CPU_0); end
      n_cmp++; if (wrt_addr_0 !== 5'd3) begin n_err++; $display("FAIL dj_addr: got %0d want 3", wrt_addr_0); end
      n_cmp++; if (wrt_data_0 !== 16'h0003) begin n_err++; $display("FAIL dj_data: got %h want 0003", wrt_data_0); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL dj_stall: got %b want 0", cpu_stall); end
      next_cycle();
      cpu_we_0 = 0;
   endtask

   task automatic test_hazard();
      logic [7:0][15:0] v;
      v = {8{16'h1357}};
      vpu_start = 1;
      next_cycle();
      vpu_start = 0;
      cpu_re_0 = 1; cpu_raddr_0 = 5'd12;
      #1;
      n_cmp++; if (cpu_hazard !== 1'b1) begin n_err++; $display("FAIL hz_busy0: got %b want 1", cpu_hazard); end
      next_cycle();
      n_cmp++; if (cpu_hazard !== 1'b1) begin n_err++; $display("FAIL hz_busy1: got %b want 1", cpu_hazard); end
      accept(v, 16'h0001);
      #1;
      n_cmp++; if (cpu_hazard !== 1'b1) begin n_err++; $display("FAIL hz_wb_cycle: got %b want 1", cpu_hazard); end
      n_cmp++; if (we_VPU !== 1'b1) begin n_err++; $display("FAIL hz_we_vpu: got %b want 1", we_VPU); end
      next_cycle();
      n_cmp++; if (cpu_hazard !== 1'b0) begin n_err++; $display("FAIL hz_cleared: got %b want 0", cpu_hazard); end
      vpu_start = 1;
      next_cycle();
      vpu_start = 0;
      cpu_raddr_0 = 5'd2;
      #1;
      n_cmp++; if (cpu_hazard !== 1'b0) begin n_err++; $display("FAIL hz_r2: got %b want 0", cpu_hazard); end
      cpu_re_0 = 0; cpu_re_1 = 1; cpu_raddr_1 = 5'd23;
      #1;
      n_cmp++; if (cpu_hazard !== 1'b1) begin n_err++; $display("FAIL hz_ro_port1: got %b want 1", cpu_hazard); end
      next_cycle();
      accept(v, 16'h0002);
      next_cycle();
      cpu_re_1 = 0;
   endtask

   task automatic test_reset_mid_pend();
      logic [7:0][15:0] v;
      v = {8{16'hDEAD}};
      accept(v, 16'hDEAD);
      cpu_we_0 = 1; cpu_waddr_0 = 5'd8;
      next_cycle();
      rst_n = 0;
      #1;
      n_cmp++; if (vpu_ready !== 1'b0) begin n_err++; $display("FAIL rp_ready: got %b want 0", vpu_ready); end
      n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL rp_we_vpu: got %b want 0", we_VPU); end
      n_cmp++; if (wrt_V !== '0) begin n_err++; $display("FAIL rp_wrt_v: got %h want 0", wrt_V); end
      cpu_we_0 = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         n_cmp++; if (we_VPU !== 1'b0) begin n_err++; $display("FAIL rp_stale%0d: got %b want 0", i, we_VPU); end
         n_cmp++; if (vpu_ready !== 1'b1) begin n_err++; $display("FAIL rp_ready%0d: got %b want 1", i, vpu_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_no_conflict();
      test_conflict_release();
      test_starvation();
      test_disjoint();
      test_hazard();
      test_reset_mid_pend();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
